dma_timing_ctrl: RTL and testbench

DMA_TIMING_CTRL -- requirements
Module: dma_timing_ctrl

---
 rtl/dma_timing_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dma_timing_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_timing_ctrl.sv
// Single-transfer DMA timing controller: four request channels, SI/S0-S4 bus cycle, sticky terminal count.
// Optional rotating priority is enabled by defining DMA_ROTATING_PRIORITY_EN (fixed priority otherwise).
module dma_timing_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [3:0]        DREQ,
  input  logic              HLDA,
  input  logic              EOP_N_IN,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              cfg_ready,
  output logic              HRQ,
  output logic [3:0]        DACK,
  output logic              aen,
  output logic              adstb,
  output logic              ior_n,
  output logic              iow_n,
  output logic              memr_n,
  output logic              memw_n,
  output logic              eop_n,
  output logic [ADDR_W-1:0] addr_out,
  output logic [3:0]        tc_status
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  state_t            state_reg;
  logic [1:0]        grant_reg;
  logic [3:0]        mask_reg;
  logic              ext_eop_reg;
  logic [ADDR_W-1:0] addr_reg  [4];
  logic [CNT_W-1:0]  count_reg [4];
  logic [1:0]        mode_reg  [4];

  logic [3:0]        req_act;
  logic              any_req;
  logic              win_found;
  logic [1:0]        win_ch;
  logic [1:0]        prio_base;
  logic              is_read;
  logic              is_write;
  logic              tc_hit;
  logic              eop_hit;

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [1:0] ptr_reg;
  assign prio_base = ptr_reg;
`else
  assign prio_base = 2'd0;
`endif

  // A masked channel is invisible to both the hold request and arbitration.
  for (genvar gi = 0; gi < 4; gi++) begin : g_req
    assign req_act[gi] = DREQ[gi] & ~mask_reg[gi];
  end

  assign any_req   = |req_act;
  assign cfg_ready = (state_reg == SI);

  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_ch    = 2'd0;
    cand      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = prio_base + 2'(i);
      if (!win_found && req_act[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
  end

  assign is_read  = (mode_reg[grant_reg] == MODE_READ);
  assign is_write = (mode_reg[grant_reg] == MODE_WRITE);
  assign tc_hit   = (count_reg[grant_reg] == '0);
  // External EOP may arrive in S2 (latched) or in S3 (taken live at the S3->S4 edge).
  assign eop_hit  = ext_eop_reg | ~EOP_N_IN;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= SI;
      grant_reg   <= 2'd0;
      mask_reg    <= 4'hF;
      ext_eop_reg <= 1'b0;
      HRQ         <= 1'b0;
      DACK        <= 4'h0;
      aen         <= 1'b0;
      adstb       <= 1'b0;
      ior_n       <= 1'b1;
      iow_n       <= 1'b1;
      memr_n      <= 1'b1;
      memw_n      <= 1'b1;
      eop_n       <= 1'b1;
      addr_out    <= '0;
      tc_status   <= 4'h0;
`ifdef DMA_ROTATING_PRIORITY_EN
      ptr_reg     <= 2'd0;
`endif
      for (int i = 0; i < 4; i++) begin
        addr_reg[i]  <= '0;
        count_reg[i] <= '0;
        mode_reg[i]  <= 2'b00;
      end
    end else begin
      case (state_reg)
        SI: begin
          if (cfg_we) begin
            addr_reg[cfg_ch]  <= cfg_addr;
            count_reg[cfg_ch] <= cfg_count;
            mode_reg[cfg_ch]  <= cfg_mode;
            mask_reg[cfg_ch]  <= 1'b0;
            tc_status[cfg_ch] <= 1'b0;
          end
          if (any_req) begin
            HRQ       <= 1'b1;
            state_reg <= S0;
          end
        end

        S0: begin
          if (!any_req) begin
            HRQ       <= 1'b0;
            state_reg <= SI;
          end else if (HLDA && win_found) begin
            grant_reg   <= win_ch;
            aen         <= 1'b1;
            adstb       <= 1'b1;
            addr_out    <= addr_reg[win_ch];
            ext_eop_reg <= 1'b0;
            state_reg   <= S1;
          end
        end

        S1: begin
          adstb     <= 1'b0;
          DACK      <= 4'b0001 << grant_reg;
          memr_n    <= ~is_read;
          ior_n     <= ~is_write;
          state_reg <= S2;
        end

        S2: begin
          if (!EOP_N_IN)
            ext_eop_reg <= 1'b1;
          iow_n     <= ~is_read;
          memw_n    <= ~is_write;
          state_reg <= S3;
        end

        S3: begin
          ior_n  <= 1'b1;
          iow_n  <= 1'b1;
          memr_n <= 1'b1;
          memw_n <= 1'b1;
          DACK   <= 4'h0;
          addr_reg[grant_reg]  <= addr_reg[grant_reg] + ADDR_W'(1);
          count_reg[grant_reg] <= count_reg[grant_reg] - CNT_W'(1);
          if (tc_hit || eop_hit) begin
            eop_n               <= 1'b0;
            tc_status[grant_reg] <= 1'b1;
            mask_reg[grant_reg]  <= 1'b1;
          end
          state_reg <= S4;
        end

        S4: begin
          HRQ         <= 1'b0;
          aen         <= 1'b0;
          eop_n       <= 1'b1;
          ext_eop_reg <= 1'b0;
`ifdef DMA_ROTATING_PRIORITY_EN
          ptr_reg     <= grant_reg + 2'd1;
`endif
          state_reg   <= SI;
        end

        default: state_reg <= SI;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Scoreboard bench for dma_timing_ctrl: stimulus queues expected bus cycles, a monitor checks each one.
module tb_dma_timing_ctrl;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic [3:0]        DREQ = 4'h0;
  logic              HLDA = 1'b0;
  logic              EOP_N_IN = 1'b1;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = 2'd0;
  logic [1:0]        cfg_mode = 2'd0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [CNT_W-1:0]  cfg_count = '0;
  logic              cfg_ready, HRQ, aen, adstb, ior_n, iow_n, memr_n, memw_n, eop_n;
  logic [3:0]        DACK, tc_status;
  logic [ADDR_W-1:0] addr_out;

  always #5 CLK = ~CLK;

  dma_timing_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N_IN(EOP_N_IN),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_addr(cfg_addr),
    .cfg_count(cfg_count), .cfg_ready(cfg_ready), .HRQ(HRQ), .DACK(DACK),
    .aen(aen), .adstb(adstb), .ior_n(ior_n), .iow_n(iow_n), .memr_n(memr_n),
    .memw_n(memw_n), .eop_n(eop_n), .addr_out(addr_out), .tc_status(tc_status)
  );

  // Strobe vectors are {ior_n, iow_n, memr_n, memw_n}.
  typedef struct {
    logic [15:0] addr;
    logic [3:0]  dack;
    logic [3:0]  s2;
    logic [3:0]  s3;
    logic        eop;
  } xfer_t;

  xfer_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [3:0] d, input logic [3:0] s2,
                      input logic [3:0] s3, input logic e);
    xfer_t x;
    x.addr = a; x.dack = d; x.s2 = s2; x.s3 = s3; x.eop = e;
    exp_q.push_back(x);
  endtask

  // Monitor: a high adstb marks S1; the next three falling edges are S2, S3, S4.
  initial begin : monitor
    int    phase;
    xfer_t got, exp;
    logic [3:0] dack3;
    phase = 0;
    dack3 = 4'h0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (adstb) begin
               got.addr = addr_out;
               chk("aen_s1", aen, 1'b1);
               phase = 1;
             end
          1: begin
               got.dack = DACK;
               got.s2   = {ior_n, iow_n, memr_n, memw_n};
               phase = 2;
             end
          2: begin
               dack3  = DACK;
               got.s3 = {ior_n, iow_n, memr_n, memw_n};
               phase = 3;
             end
          default: begin
            got.eop = eop_n;
            chk("s4_strobes", {ior_n, iow_n, memr_n, memw_n}, 4'hF);
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_xfer: got addr 0x%0h dack %b, expected no transfer",
                       got.addr, got.dack);
            end else begin
              exp = exp_q.pop_front();
              $display("xfer addr=0x%04h dack=%b s2=%b s3=%b eop_n=%b", got.addr, got.dack,
                       got.s2, got.s3, got.eop);
              chk("addr", got.addr, exp.addr);
              chk("dack_s2", got.dack, exp.dack);
              chk("dack_s3", dack3, exp.dack);
              chk("strobes_s2", got.s2, exp.s2);
              chk("strobes_s3", got.s3, exp.s3);
              chk("eop_n_s4", got.eop, exp.eop);
            end
            phase = 0;
          end
        endcase
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hrq"}, HRQ, 1'b0);
    chk({tag, "_dack"}, DACK, 4'h0);
    chk({tag, "_aen_adstb"}, {aen, adstb}, 2'b00);
    chk({tag, "_strobes"}, {ior_n, iow_n, memr_n, memw_n}, 4'hF);
    chk({tag, "_eop_n"}, eop_n, 1'b1);
    chk({tag, "_addr_out"}, addr_out, 16'h0000);
    chk({tag, "_tc_status"}, tc_status, 4'h0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    DREQ = 4'h0; HLDA = 1'b0; EOP_N_IN = 1'b1; cfg_we = 1'b0;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] a,
                     input logic [15:0] c);
    @(negedge CLK);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_addr = a; cfg_count = c;
    @(negedge CLK);
    cfg_we = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      @(negedge CLK);
      t++;
    end
    chk({name, "_pending_xfers"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_s1(input string name, input int max_cyc);
    int t;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!adstb && t < max_cyc);
    chk({name, "_reach_s1"}, adstb, 1'b1);
  endtask

  task automatic idle_hrq(input string name, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge CLK);
      chk(name, HRQ, 1'b0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    // All channels masked out of reset.
    DREQ = 4'hF; HLDA = 1'b1;
    idle_hrq("masked_after_reset_hrq", 4);
    DREQ = 4'h0;

    // Ch1 read, three transfers, terminal count on the third.
    do_reset();
    cfg(2'd1, 2'b10, 16'h1000, 16'h0002);
    push(16'h1000, 4'b0010, 4'hD, 4'h9, 1'b1);
    push(16'h1001, 4'b0010, 4'hD, 4'h9, 1'b1);
    push(16'h1002, 4'b0010, 4'hD, 4'h9, 1'b0);
    DREQ = 4'b0010; HLDA = 1'b1;
    wait_drain("ch1_read", 80);
    chk("ch1_tc_status", tc_status, 4'b0010);
    idle_hrq("ch1_masked_hrq", 6);
    DREQ = 4'h0;

    // All four requesting with HLDA tied high.
    do_reset();
    cfg(2'd0, 2'b10, 16'h0100, 16'h00FF);
    cfg(2'd1, 2'b10, 16'h0200, 16'h00FF);
    cfg(2'd2, 2'b10, 16'h0300, 16'h00FF);
    cfg(2'd3, 2'b10, 16'h0400, 16'h00FF);
`ifdef DMA_ROTATING_PRIORITY_EN
    push(16'h0100, 4'b0001, 4'hD, 4'h9, 1'b1);
    push(16'h0200, 4'b0010, 4'hD, 4'h9, 1'b1);
    push(16'h0300, 4'b0100, 4'hD, 4'h9, 1'b1);
    push(16'h0400, 4'b1000, 4'hD, 4'h9, 1'b1);
`else
    push(16'h0100, 4'b0001, 4'hD, 4'h9, 1'b1);
    push(16'h0101, 4'b0001, 4'hD, 4'h9, 1'b1);
    push(16'h0102, 4'b0001, 4'hD, 4'h9, 1'b1);
    push(16'h0103, 4'b0001, 4'hD, 4'h9, 1'b1);
`endif
    DREQ = 4'hF; HLDA = 1'b1;
    wait_drain("priority", 80);
    DREQ = 4'h0;
    repeat (4) @(negedge CLK);

    // Ch2 write at 0xFFFF, external EOP in S3 of the first transfer.
    do_reset();
    cfg(2'd2, 2'b01, 16'hFFFF, 16'h0005);
    push(16'hFFFF, 4'b0100, 4'h7, 4'h6, 1'b0);
    DREQ = 4'b0100; HLDA = 1'b1;
    wait_s1("ext_eop", 20);
    @(negedge CLK);
    @(negedge CLK);
    EOP_N_IN = 1'b0;
    @(negedge CLK);
    EOP_N_IN = 1'b1;
    wait_drain("ext_eop", 20);
    chk("ext_eop_tc_status", tc_status, 4'b0100);
    idle_hrq("ext_eop_masked_hrq", 5);
    DREQ = 4'h0;

    // Address wrap 0xFFFF -> 0x0000 on a two-transfer ch2 write.
    do_reset();
    cfg(2'd2, 2'b01, 16'hFFFF, 16'h0001);
    push(16'hFFFF, 4'b0100, 4'h7, 4'h6, 1'b1);
    push(16'h0000, 4'b0100, 4'h7, 4'h6, 1'b0);
    DREQ = 4'b0100; HLDA = 1'b1;
    wait_drain("addr_wrap", 40);
    DREQ = 4'h0;

    // Ch0 verify: DACK only, no strobes.
    do_reset();
    cfg(2'd0, 2'b00, 16'h0040, 16'h0000);
    push(16'h0040, 4'b0001, 4'hF, 4'hF, 1'b0);
    DREQ = 4'b0001; HLDA = 1'b1;
    wait_drain("verify", 20);
    chk("verify_tc_status", tc_status, 4'b0001);
    DREQ = 4'h0;

    // Reset asserted during S3 of a ch3 read.
    do_reset();
    cfg(2'd3, 2'b10, 16'h3000, 16'h0005);
    DREQ = 4'b1000; HLDA = 1'b1;
    wait_s1("mid_reset", 20);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_reset_s3_strobes", {ior_n, iow_n, memr_n, memw_n}, 4'h9);
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    idle_hrq("post_reset_ch3_hrq", 6);
    DREQ = 4'h0;

    // Config write during S2 is dropped.
    do_reset();
    cfg(2'd1, 2'b10, 16'h2000, 16'h0003);
    push(16'h2000, 4'b0010, 4'hD, 4'h9, 1'b1);
    push(16'h2001, 4'b0010, 4'hD, 4'h9, 1'b1);
    DREQ = 4'b0010; HLDA = 1'b1;
    wait_s1("cfg_drop", 20);
    @(negedge CLK);
    chk("cfg_ready_s2", cfg_ready, 1'b0);
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b00; cfg_addr = 16'h5555; cfg_count = 16'h0000;
    @(negedge CLK);
    cfg_we = 1'b0;
    wait_drain("cfg_drop", 40);
    DREQ = 4'h0;
    repeat (3) @(negedge CLK);

    // Request withdrawn while waiting for HLDA in S0.
    HLDA = 1'b0;
    DREQ = 4'b0010;
    @(negedge CLK);
    chk("s0_hrq_raised", HRQ, 1'b1);
    DREQ = 4'h0;
    @(negedge CLK);
    chk("s0_withdraw_hrq", HRQ, 1'b0);
    chk("s0_withdraw_cfg_ready", cfg_ready, 1'b1);
    repeat (5) @(negedge CLK);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
